// File: rtl/logic_op_pkg.sv
// logic_op_pkg
// Shared definitions for the logic_op_pipeline block:
//   op_e          two-bit function select (NOR, NAND, XOR, XNOR)
//   MAX_W         widest operand the vector helper supports
//   apply_op_bit  one-bit evaluation of the selected function
//   apply_op      MAX_W-bit bitwise evaluation of the selected function
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_NOR  = 2'b00,
    OP_NAND = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  localparam int unsigned MAX_W = 64;

  function automatic logic apply_op_bit(input logic a, input logic b, input op_e op);
    logic r;
    unique case (op)
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // Callers narrower than MAX_W zero-extend operands and keep the low bits of the result.
  function automatic logic [MAX_W-1:0] apply_op(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input op_e op);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = apply_op_bit(a[i], b[i], op);
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_op_stage.sv
// logic_op_stage
// One pipeline register holding a data word and its valid bit.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset, clears data and valid
//   i_en     load enable; when low the stage holds
//   i_data   data to load
//   i_valid  valid to load
//   o_data   registered data
//   o_valid  registered valid
module logic_op_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Data loads regardless of valid so the register never holds X after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/logic_op_pipeline.sv
// logic_op_pipeline
// Applies a selectable bitwise function to two operands and carries the result through
// STAGES register stages under a valid/ready handshake, counting delivered results.
// Ports:
//   i_clk, i_rst      clock and asynchronous active-high reset
//   i_a, i_b, i_op    operands and function select (00 NOR, 01 NAND, 10 XOR, 11 XNOR)
//   i_valid, o_ready  input handshake
//   o_c, o_zero       last-stage result and its zero flag (qualified by o_valid)
//   o_valid, i_ready  output handshake
//   o_count           output handshakes since reset, wraps modulo 2^COUNT_W
module logic_op_pipeline
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [1:0]         i_op,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WIDTH-1:0]   o_c,
  output logic               o_zero,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COUNT_W-1:0] o_count
);

  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_data [STAGES+1];
  logic [STAGES:0]    w_valid;
  logic               w_adv;
  logic [COUNT_W-1:0] r_count;

  always_comb begin
    w_res = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_res[i] = apply_op_bit(i_a[i], i_b[i], op_e'(i_op));
    end
  end

  // Index 0 is the combinational front end; index k+1 is the output of stage k.
  assign w_data[0]  = w_res;
  assign w_valid[0] = i_valid;

  // Single global enable: the whole pipe moves unless the last stage is full and stalled.
  assign w_adv = ~w_valid[STAGES] | i_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic_op_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (w_adv),
      .i_data (w_data[k]),
      .i_valid(w_valid[k]),
      .o_data (w_data[k+1]),
      .o_valid(w_valid[k+1])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_valid[STAGES] & i_ready) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_ready = w_adv;
  assign o_c     = w_data[STAGES];
  assign o_valid = w_valid[STAGES];
  assign o_zero  = w_valid[STAGES] & (w_data[STAGES] == '0);
  assign o_count = r_count;

endmodule

// File: tb/tb_logic_op_pipeline.sv
// tb_logic_op_pipeline
// Two instances: the default build (WIDTH 8, STAGES 2, COUNT_W 16) and a narrow build
// (WIDTH 1, STAGES 1, COUNT_W 2). A slot model of each pipe is advanced every cycle and
// compared with the outputs half a cycle before each rising edge.
module tb_logic_op_pipeline;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  a0, b0, c0;
  logic [1:0]  op0;
  logic        v0, rdy0, ordy0, z0, ov0;
  logic [15:0] cnt0;

  logic [0:0]  a1, b1, c1;
  logic [1:0]  op1;
  logic        v1, rdy1, ordy1, z1, ov1;
  logic [1:0]  cnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: one slot per stage, last slot is the output.
  logic        m0v [S0];
  logic [63:0] m0d [S0];
  int unsigned m0cnt;
  logic        m1v [S1];
  logic [63:0] m1d [S1];
  int unsigned m1cnt;

  always #5 clk = ~clk;

  logic_op_pipeline #(.WIDTH(8), .STAGES(S0), .COUNT_W(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_a(a0), .i_b(b0), .i_op(op0), .i_valid(v0),
    .o_ready(ordy0), .o_c(c0), .o_zero(z0), .o_valid(ov0), .i_ready(rdy0), .o_count(cnt0)
  );

  logic_op_pipeline #(.WIDTH(1), .STAGES(S1), .COUNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_a(a1), .i_b(b1), .i_op(op1), .i_valid(v1),
    .o_ready(ordy1), .o_c(c1), .o_zero(z1), .o_valid(ov1), .i_ready(rdy1), .o_count(cnt1)
  );

  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return ~(a | b);
      2'd1:    return ~(a & b);
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < S0; k++) begin m0v[k] = 1'b0; m0d[k] = '0; end
    for (int k = 0; k < S1; k++) begin m1v[k] = 1'b0; m1d[k] = '0; end
    m0cnt = 0;
    m1cnt = 0;
  endtask

  // Called at posedge+1 with inputs set; checks at negedge, advances the model at posedge.
  task automatic tick();
    logic adv0, adv1;
    @(negedge clk);
    adv0 = rst | ~m0v[S0-1] | rdy0;
    adv1 = rst | ~m1v[S1-1] | rdy1;
    check("ready0", 64'(ordy0), 64'(adv0));
    check("valid0", 64'(ov0), 64'(m0v[S0-1]));
    if (m0v[S0-1]) check("data0", 64'(c0), m0d[S0-1]);
    check("zero0", 64'(z0), 64'(m0v[S0-1] && m0d[S0-1] == 0));
    check("count0", 64'(cnt0), 64'(m0cnt));
    check("ready1", 64'(ordy1), 64'(adv1));
    check("valid1", 64'(ov1), 64'(m1v[S1-1]));
    if (m1v[S1-1]) check("data1", 64'(c1), m1d[S1-1]);
    check("zero1", 64'(z1), 64'(m1v[S1-1] && m1d[S1-1] == 0));
    check("count1", 64'(cnt1), 64'(m1cnt));
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (m0v[S0-1] && rdy0) m0cnt = (m0cnt + 1) % 65536;
      if (m1v[S1-1] && rdy1) m1cnt = (m1cnt + 1) % 4;
      if (adv0) begin
        for (int k = S0 - 1; k > 0; k--) begin m0v[k] = m0v[k-1]; m0d[k] = m0d[k-1]; end
        m0v[0] = v0;
        m0d[0] = ref_op(64'(a0), 64'(b0), op0) & 64'hFF;
      end
      if (adv1) begin
        for (int k = S1 - 1; k > 0; k--) begin m1v[k] = m1v[k-1]; m1d[k] = m1d[k-1]; end
        m1v[0] = v1;
        m1d[0] = ref_op(64'(a1), 64'(b1), op1) & 64'h1;
      end
    end
    #1;
  endtask

  logic [7:0]  bp_a [6];
  logic [7:0]  bp_b [6];
  logic [1:0]  bp_op [6];
  int          idx;
  logic        saw_stall;
  logic [15:0] cnt_start;
  int          exp_wrap [6];

  initial begin
    rst = 1'b1;
    a0 = '0; b0 = '0; op0 = '0; v0 = 1'b0; rdy0 = 1'b1;
    a1 = '0; b1 = '0; op1 = '0; v1 = 1'b0; rdy1 = 1'b1;
    model_clear();
    #1;
    check("rst_c0", 64'(c0), 64'h0);
    check("rst_valid0", 64'(ov0), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Counter wrap on the 2-bit build: one handshake per cycle once the pipe is full.
    exp_wrap = '{0, 1, 2, 3, 0, 1};
    v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      op1 = 2'($urandom_range(0, 3));
      tick();
      check("wrap_count1", 64'(cnt1), 64'(exp_wrap[i]));
    end
    v1 = 1'b0;
    tick();

    // Single NOR beat of zeros on both builds.
    v0 = 1'b1; a0 = 8'h00; b0 = 8'h00; op0 = 2'd0;
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = 2'd0;
    cnt_start = cnt0;
    tick();
    check("w1_nor00_c", 64'(c1), 64'h1);
    check("w1_nor00_valid", 64'(ov1), 64'h1);
    v0 = 1'b0;
    a1 = 1'b1;
    tick();
    check("w1_nor10_c", 64'(c1), 64'h0);
    check("nor_c", 64'(c0), 64'hFF);
    check("nor_valid", 64'(ov0), 64'h1);
    check("nor_zero", 64'(z0), 64'h0);
    v1 = 1'b0;
    tick();
    check("nor_count", 64'(cnt0 - cnt_start), 64'h1);
    tick();

    // Back-to-back beats of every function, then equal-operand XNOR/XOR.
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1;
      a0 = (i < 4) ? 8'hF0 : 8'hA5;
      b0 = (i < 4) ? 8'hCC : 8'hA5;
      op0 = (i < 4) ? 2'(i) : ((i == 4) ? 2'd3 : 2'd2);
      tick();
      if (i == 1) check("b2b_nor_c", 64'(c0), 64'h03);
      if (i == 2) check("b2b_nand_c", 64'(c0), 64'h3F);
      if (i == 3) check("b2b_xor_c", 64'(c0), 64'h3C);
      if (i == 4) check("b2b_xnor_c", 64'(c0), 64'hC3);
      if (i == 5) check("b2b_xnor_eq_c", 64'(c0), 64'hFF);
    end
    v0 = 1'b0;
    tick();
    check("b2b_xor_eq_c", 64'(c0), 64'h00);
    check("b2b_xor_eq_zero", 64'(z0), 64'h1);
    tick();

    // Backpressure: source holds each beat until accepted; sink stalls for 4 cycles.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); bp_op[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    saw_stall = 1'b0;
    cnt_start = cnt0;
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      logic acc;
      v0 = 1'b1; a0 = bp_a[idx]; b0 = bp_b[idx]; op0 = bp_op[idx];
      rdy0 = (cyc >= 2 && cyc < 6) ? 1'b0 : 1'b1;
      acc = ~m0v[S0-1] | rdy0;
      tick();
      if (!acc) saw_stall = 1'b1;
      if (acc) idx++;
    end
    v0 = 1'b0;
    rdy0 = 1'b1;
    check("bp_all_sent", 64'(idx), 64'd6);
    check("bp_stall_seen", 64'(saw_stall), 64'h1);
    for (int i = 0; i < 4; i++) tick();
    check("bp_count", 64'(cnt0 - cnt_start), 64'd6);

    // Asynchronous reset between edges with two beats in flight.
    v0 = 1'b1; a0 = 8'h12; b0 = 8'h34; op0 = 2'd2;
    tick();
    a0 = 8'h56;
    tick();
    v0 = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid0", 64'(ov0), 64'h0);
    check("arst_c0", 64'(c0), 64'h0);
    check("arst_count0", 64'(cnt0), 64'h0);
    check("arst_ready0", 64'(ordy0), 64'h1);
    check("arst_count1", 64'(cnt1), 64'h0);
    model_clear();
    #1;
    tick();
    tick();
    rst = 1'b0;
    v0 = 1'b1; a0 = 8'h5A; b0 = 8'h0F; op0 = 2'd2;
    tick();
    v0 = 1'b0;
    check("post_rst_not_yet", 64'(ov0), 64'h0);
    tick();
    check("post_rst_valid", 64'(ov0), 64'h1);
    check("post_rst_c", 64'(c0), 64'h55);
    tick();

    // Random traffic on both builds.
    for (int i = 0; i < 300; i++) begin
      v0 = 1'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom);
      rdy0 = ($urandom_range(0, 3) != 0);
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); op1 = 2'($urandom);
      rdy1 = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
